// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard
// detection. Decoded operands and control from ID are captured on each rising
// edge. The EX-stage ALU operands are resolved against the EX/MEM and MEM/WB
// stages. The writeback and memory controls are passed downstream.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   hold                global freeze, so the register keeps its contents
//   flush               squash the incoming ID instruction
//   id_*                decoded operands and control from ID
//   exm_*               EX/MEM destination and result, used for forwarding
//   mwb_*               MEM/WB destination and writeback value, used for forwarding
//   alu_in1, alu_in2    forwarded ALU operands
//   alu_op, alu_sign    registered ALU control, zero while the slot is empty
//   ex_store_data       forwarded rt value for stores
//   ex_wr_addr          registered destination register
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
//                       registered controls, zero while the slot is empty
//   load_use_stall      ID/IF must hold this cycle. A bubble is inserted here.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          flush,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_wr_addr,
    input  logic          id_uses_rt,
    input  logic [3:0]    id_alu_op,
    input  logic          id_sign,
    input  logic          id_alu_src1,
    input  logic          id_alu_src2,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic [1:0]    id_mem_to_reg,
    input  logic          exm_reg_write,
    input  logic [AW-1:0] exm_wr_addr,
    input  logic [DW-1:0] exm_data,
    input  logic          mwb_reg_write,
    input  logic [AW-1:0] mwb_wr_addr,
    input  logic [DW-1:0] mwb_data,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [3:0]    alu_op,
    output logic          alu_sign,
    output logic [DW-1:0] ex_store_data,
    output logic [AW-1:0] ex_wr_addr,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic [1:0]    ex_mem_to_reg,
    output logic          load_use_stall
);

    // ------------------------------------------------------------------
    // Pipeline register state
    // ------------------------------------------------------------------
    logic          valid_reg,      valid_next;
    logic [DW-1:0] rs_data_reg,    rs_data_next;
    logic [DW-1:0] rt_data_reg,    rt_data_next;
    logic [DW-1:0] imm_reg,        imm_next;
    logic [4:0]    shamt_reg,      shamt_next;
    logic [AW-1:0] rs_reg,         rs_next;
    logic [AW-1:0] rt_reg,         rt_next;
    logic [AW-1:0] wr_addr_reg,    wr_addr_next;
    logic [3:0]    alu_op_reg,     alu_op_next;
    logic          sign_reg,       sign_next;
    logic          alu_src1_reg,   alu_src1_next;
    logic          alu_src2_reg,   alu_src2_next;
    logic          reg_write_reg,  reg_write_next;
    logic          mem_read_reg,   mem_read_next;
    logic          mem_write_reg,  mem_write_next;
    logic [1:0]    mem_to_reg_reg, mem_to_reg_next;

    logic bubble;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX produces its value too late to be
    // forwarded to the instruction that is in ID now. The wr_addr!=0 check
    // keeps loads to r0 from causing a stall, because r0 is never forwarded.
    // The stall is masked during hold. A frozen pipe must not see a
    // request that would move it.
    // ------------------------------------------------------------------
    logic ex_load_live;
    logic rs_conflict;
    logic rt_conflict;

    assign ex_load_live   = valid_reg & mem_read_reg & (wr_addr_reg != '0);
    assign rs_conflict    = (wr_addr_reg == id_rs);
    assign rt_conflict    = id_uses_rt & (wr_addr_reg == id_rt);
    assign load_use_stall = ~hold & ex_load_live & (rs_conflict | rt_conflict);

    // A squashed or stalled instruction becomes a bubble. Hold has
    // priority and is handled first in the next-state logic.
    assign bubble = flush | load_use_stall;

    // ------------------------------------------------------------------
    // Next-state selection: hold > bubble > load
    // ------------------------------------------------------------------
    always_comb begin
        valid_next      = valid_reg;
        rs_data_next    = rs_data_reg;
        rt_data_next    = rt_data_reg;
        imm_next        = imm_reg;
        shamt_next      = shamt_reg;
        rs_next         = rs_reg;
        rt_next         = rt_reg;
        wr_addr_next    = wr_addr_reg;
        alu_op_next     = alu_op_reg;
        sign_next       = sign_reg;
        alu_src1_next   = alu_src1_reg;
        alu_src2_next   = alu_src2_reg;
        reg_write_next  = reg_write_reg;
        mem_read_next   = mem_read_reg;
        mem_write_next  = mem_write_reg;
        mem_to_reg_next = mem_to_reg_reg;

        if (hold) begin
            // keep everything
        end else if (bubble) begin
            // The data fields do not matter in a bubble. They are zeroed
            // so that a bubble looks the same as the reset state.
            valid_next      = 1'b0;
            rs_data_next    = '0;
            rt_data_next    = '0;
            imm_next        = '0;
            shamt_next      = '0;
            rs_next         = '0;
            rt_next         = '0;
            wr_addr_next    = '0;
            alu_op_next     = '0;
            sign_next       = 1'b0;
            alu_src1_next   = 1'b0;
            alu_src2_next   = 1'b0;
            reg_write_next  = 1'b0;
            mem_read_next   = 1'b0;
            mem_write_next  = 1'b0;
            mem_to_reg_next = '0;
        end else begin
            valid_next      = 1'b1;
            rs_data_next    = id_rs_data;
            rt_data_next    = id_rt_data;
            imm_next        = id_imm;
            shamt_next      = id_shamt;
            rs_next         = id_rs;
            rt_next         = id_rt;
            wr_addr_next    = id_wr_addr;
            alu_op_next     = id_alu_op;
            sign_next       = id_sign;
            alu_src1_next   = id_alu_src1;
            alu_src2_next   = id_alu_src2;
            reg_write_next  = id_reg_write;
            mem_read_next   = id_mem_read;
            mem_write_next  = id_mem_write;
            mem_to_reg_next = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            rs_data_reg    <= '0;
            rt_data_reg    <= '0;
            imm_reg        <= '0;
            shamt_reg      <= '0;
            rs_reg         <= '0;
            rt_reg         <= '0;
            wr_addr_reg    <= '0;
            alu_op_reg     <= '0;
            sign_reg       <= 1'b0;
            alu_src1_reg   <= 1'b0;
            alu_src2_reg   <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= '0;
        end else begin
            valid_reg      <= valid_next;
            rs_data_reg    <= rs_data_next;
            rt_data_reg    <= rt_data_next;
            imm_reg        <= imm_next;
            shamt_reg      <= shamt_next;
            rs_reg         <= rs_next;
            rt_reg         <= rt_next;
            wr_addr_reg    <= wr_addr_next;
            alu_op_reg     <= alu_op_next;
            sign_reg       <= sign_next;
            alu_src1_reg   <= alu_src1_next;
            alu_src2_reg   <= alu_src2_next;
            reg_write_reg  <= reg_write_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            mem_to_reg_reg <= mem_to_reg_next;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding. Index 0 is rs and index 1 is rt. The younger
    // EX/MEM result wins over MEM/WB. Register 0 is never forwarded and
    // reads as the latched value.
    // ------------------------------------------------------------------
    logic [AW-1:0] src_addr    [2];
    logic [DW-1:0] src_latched [2];
    logic [DW-1:0] fwd_data    [2];

    assign src_addr[0]    = rs_reg;
    assign src_addr[1]    = rt_reg;
    assign src_latched[0] = rs_data_reg;
    assign src_latched[1] = rt_data_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic exm_hit;
            logic mwb_hit;

            assign exm_hit = exm_reg_write & (exm_wr_addr != '0) &
                             (exm_wr_addr == src_addr[gi]);
            assign mwb_hit = mwb_reg_write & (mwb_wr_addr != '0) &
                             (mwb_wr_addr == src_addr[gi]);

            assign fwd_data[gi] = exm_hit ? exm_data :
                                  mwb_hit ? mwb_data :
                                            src_latched[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs. The controls are gated by valid so that an empty slot can
    // never write or access memory. alu_op=0 makes the ALU output 0.
    // ------------------------------------------------------------------
    assign alu_in1       = alu_src1_reg ? {{(DW-5){1'b0}}, shamt_reg} : fwd_data[0];
    assign alu_in2       = alu_src2_reg ? imm_reg : fwd_data[1];
    assign ex_store_data = fwd_data[1];

    assign alu_op        = valid_reg ? alu_op_reg     : 4'd0;
    assign alu_sign      = valid_reg & sign_reg;
    assign ex_wr_addr    = valid_reg ? wr_addr_reg    : '0;
    assign ex_reg_write  = valid_reg & reg_write_reg;
    assign ex_mem_read   = valid_reg & mem_read_reg;
    assign ex_mem_write  = valid_reg & mem_write_reg;
    assign ex_mem_to_reg = valid_reg ? mem_to_reg_reg : 2'd0;

endmodule
